// File: rtl/unidade_despacho_if.sv
// rtl/unidade_despacho_if.sv - queue and reservation-station signals of the dispatch unit
interface unidade_despacho_if #(
    parameter int NUM_ER_R = 3,
    parameter int NUM_ER_I = 2
);
    logic [15:0]         Instrucao;
    logic                Empty;
    logic                Flush;
    logic [NUM_ER_R-1:0] ER_R_Busy;
    logic [NUM_ER_I-1:0] ER_I_Busy;
    logic                Pop;
    logic [NUM_ER_R-1:0] ER_R_Wr;
    logic [NUM_ER_I-1:0] ER_I_Wr;
    logic [15:0]         Instr_Out;
    logic [2:0]          Tag;
    logic                Ocupado;

    modport master (
        input  Instrucao, Empty, Flush, ER_R_Busy, ER_I_Busy,
        output Pop, ER_R_Wr, ER_I_Wr, Instr_Out, Tag, Ocupado
    );

    modport slave (
        output Instrucao, Empty, Flush, ER_R_Busy, ER_I_Busy,
        input  Pop, ER_R_Wr, ER_I_Wr, Instr_Out, Tag, Ocupado
    );
endinterface

// File: rtl/unidade_despacho.sv
// rtl/unidade_despacho.sv - pops the instruction queue and writes each instruction into a free reservation station
// Optional DESPACHO_CONTADORES_EN adds Emitidas/Descartadas/Stalls event counters.
module unidade_despacho #(
    parameter int NUM_ER_R = 3,
    parameter int NUM_ER_I = 2
) (
    input  logic               Clock,
    input  logic               Reset_n,
    unidade_despacho_if.master bus
`ifdef DESPACHO_CONTADORES_EN
    ,
    output logic [7:0]         Emitidas,
    output logic [7:0]         Descartadas,
    output logic [7:0]         Stalls
`endif
);
    localparam logic [2:0]  OP_ADD = 3'd2;
    localparam logic [2:0]  OP_SUB = 3'd3;
    localparam logic [2:0]  OP_LD  = 3'd4;
    localparam logic [2:0]  OP_ST  = 3'd5;
    localparam logic [15:0] SLOT_VAZIO = 16'h0005;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        EMITE  = 2'd2
    } estado_t;

    estado_t             estado_q, estado_d;
    logic                pop_q, pop_d;
    logic [NUM_ER_R-1:0] wr_r_q, wr_r_d, sel_r;
    logic [NUM_ER_I-1:0] wr_i_q, wr_i_d, sel_i;
    logic [15:0]         instr_q, instr_d;
    logic [2:0]          tag_q, tag_d, tag_r, tag_i;
    logic                livre_r, livre_i, op_r, op_i;

    assign op_r = (instr_q[15:13] == OP_ADD) || (instr_q[15:13] == OP_SUB);
    assign op_i = (instr_q[15:13] == OP_LD)  || (instr_q[15:13] == OP_ST);

    // Descending scan so the lowest free index is the one left standing.
    always_comb begin
        sel_r   = '0;
        tag_r   = '0;
        livre_r = 1'b0;
        for (int i = NUM_ER_R - 1; i >= 0; i--) begin
            if (!bus.ER_R_Busy[i]) begin
                sel_r    = '0;
                sel_r[i] = 1'b1;
                tag_r    = 3'(i + 1);
                livre_r  = 1'b1;
            end
        end
        sel_i   = '0;
        tag_i   = '0;
        livre_i = 1'b0;
        for (int j = NUM_ER_I - 1; j >= 0; j--) begin
            if (!bus.ER_I_Busy[j]) begin
                sel_i    = '0;
                sel_i[j] = 1'b1;
                tag_i    = 3'(NUM_ER_R + j + 1);
                livre_i  = 1'b1;
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        pop_d    = 1'b0;
        wr_r_d   = '0;
        wr_i_d   = '0;
        tag_d    = '0;
        instr_d  = instr_q;
        if (bus.Flush) begin
            estado_d = OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (!bus.Empty) begin
                        pop_d    = 1'b1;
                        estado_d = BUSCA;
                    end
                end
                BUSCA: begin
                    instr_d  = bus.Instrucao;
                    estado_d = EMITE;
                end
                EMITE: begin
                    // With no free station of the needed class we simply stay here.
                    if (op_r) begin
                        if (livre_r) begin
                            wr_r_d   = sel_r;
                            tag_d    = tag_r;
                            estado_d = OCIOSO;
                        end
                    end else if (op_i) begin
                        if (livre_i) begin
                            wr_i_d   = sel_i;
                            tag_d    = tag_i;
                            estado_d = OCIOSO;
                        end
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q <= OCIOSO;
            pop_q    <= 1'b0;
            wr_r_q   <= '0;
            wr_i_q   <= '0;
            instr_q  <= SLOT_VAZIO;
            tag_q    <= '0;
        end else begin
            estado_q <= estado_d;
            pop_q    <= pop_d;
            wr_r_q   <= wr_r_d;
            wr_i_q   <= wr_i_d;
            instr_q  <= instr_d;
            tag_q    <= tag_d;
        end
    end

    assign bus.Pop       = pop_q;
    assign bus.ER_R_Wr   = wr_r_q;
    assign bus.ER_I_Wr   = wr_i_q;
    assign bus.Instr_Out = instr_q;
    assign bus.Tag       = tag_q;
    assign bus.Ocupado   = (estado_q != OCIOSO);

`ifdef DESPACHO_CONTADORES_EN
    logic       emite, descarta, para;
    logic [7:0] emitidas_q, emitidas_d, descartadas_q, descartadas_d, stalls_q, stalls_d;

    assign emite    = (|wr_r_d) || (|wr_i_d);
    assign descarta = !bus.Flush && (estado_q == EMITE) && !op_r && !op_i;
    assign para     = !bus.Flush && (estado_q == EMITE) &&
                      ((op_r && !livre_r) || (op_i && !livre_i));

    always_comb begin
        emitidas_d    = emite    ? 8'(emitidas_q + 8'd1)    : emitidas_q;
        descartadas_d = descarta ? 8'(descartadas_q + 8'd1) : descartadas_q;
        stalls_d      = para     ? 8'(stalls_q + 8'd1)      : stalls_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            emitidas_q    <= '0;
            descartadas_q <= '0;
            stalls_q      <= '0;
        end else begin
            emitidas_q    <= emitidas_d;
            descartadas_q <= descartadas_d;
            stalls_q      <= stalls_d;
        end
    end

    assign Emitidas    = emitidas_q;
    assign Descartadas = descartadas_q;
    assign Stalls      = stalls_q;
`endif
endmodule

// File: tb/tb_unidade_despacho.sv
// tb/tb_unidade_despacho.sv - scoreboard bench for unidade_despacho with queue and station models
module tb_unidade_despacho;
    localparam int NR = 3;
    localparam int NI = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unidade_despacho_if #(.NUM_ER_R(NR), .NUM_ER_I(NI)) bus ();
`ifdef DESPACHO_CONTADORES_EN
    logic [7:0] emitidas, descartadas, stalls;
`endif

    unidade_despacho #(.NUM_ER_R(NR), .NUM_ER_I(NI)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
`ifdef DESPACHO_CONTADORES_EN
        ,
        .Emitidas    (emitidas),
        .Descartadas (descartadas),
        .Stalls      (stalls)
`endif
    );

    typedef struct {
        logic [15:0] instr;
        bit          is_r;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] iq[$];
    exp_t        sb[$];
    logic [NR-1:0] busy_r = '0, force_r = '0, snap_r = '0;
    logic [NI-1:0] busy_i = '0, force_i = '0, snap_i = '0;
    bit          pause = 1'b0;
    bit          rand_en = 1'b0;
    bit          prev_pop = 1'b0;
    int          n_writes = 0;
    int          n_invalid = 0;

    assign bus.ER_R_Busy = busy_r | force_r;
    assign bus.ER_I_Busy = busy_i | force_i;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 1 = R-type, 2 = I-type, 0 = discarded
    function automatic int classe(logic [15:0] ins);
        case (ins[15:13])
            3'd2, 3'd3: return 1;
            3'd4, 3'd5: return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic int lowest_free(logic [31:0] busy, int n);
        for (int k = 0; k < n; k++) if (!busy[k]) return k;
        return -1;
    endfunction

    task automatic push(logic [15:0] ins);
        exp_t e;
        iq.push_back(ins);
        if (classe(ins) == 0) n_invalid++;
        else begin
            e.instr = ins;
            e.is_r  = (classe(ins) == 1);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pop();
        int c = 0;
        do begin
            step();
            c++;
        end while (bus.Pop !== 1'b1 && c < 20);
        check("pop_seen", 32'(bus.Pop), 1);
    endtask

    task automatic drain();
        int c = 0;
        while (c < 3000 && !(iq.size() == 0 && sb.size() == 0 && bus.Ocupado == 1'b0 && bus.Pop == 1'b0)) begin
            step();
            c++;
        end
        check("drain_done", 32'(c < 3000), 1);
        step();
        step();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_pop"},     32'(bus.Pop), 0);
        check({tag, "_wr"},      32'({bus.ER_R_Wr, bus.ER_I_Wr}), 0);
        check({tag, "_tag"},     32'(bus.Tag), 0);
        check({tag, "_instr"},   32'(bus.Instr_Out), 32'h0005);
        check({tag, "_ocupado"}, 32'(bus.Ocupado), 0);
`ifdef DESPACHO_CONTADORES_EN
        check({tag, "_counters"}, 32'({emitidas, descartadas, stalls}), 0);
`endif
    endtask

    // Instruction queue model: serves a Pop at the negedge of the Pop cycle.
    always @(negedge clk) begin
        if (bus.Pop === 1'b1) begin
            check("pop_not_consecutive", 32'(prev_pop), 0);
            check("pop_queue_nonempty", 32'(iq.size() != 0), 1);
            if (iq.size() != 0) bus.Instrucao = iq.pop_front();
        end
        prev_pop  = bus.Pop;
        bus.Empty = pause || (iq.size() == 0);
    end

    always @(posedge clk) begin
        snap_r <= bus.ER_R_Busy;
        snap_i <= bus.ER_I_Busy;
    end

    // Monitor and station model: every strobe is checked against the scoreboard head.
    always @(negedge clk) begin : monitor
        logic [NR-1:0] wr_r;
        logic [NI-1:0] wr_i;
        exp_t e;
        int idx;
        wr_r = bus.ER_R_Wr;
        wr_i = bus.ER_I_Wr;
        if (wr_r == '0 && wr_i == '0) begin
            check("tag_idle", 32'(bus.Tag), 0);
        end else begin
            n_writes++;
            check("wr_onehot", $countones({wr_r, wr_i}), 1);
            if (sb.size() == 0) begin
                check("write_expected", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check("sb_instr_out", 32'(bus.Instr_Out), 32'(e.instr));
                if (e.is_r) begin
                    idx = lowest_free(32'(snap_r), NR);
                    check("sb_er_r_wr", 32'(wr_r), 32'(1) << idx);
                    check("sb_er_i_quiet", 32'(wr_i), 0);
                    check("sb_tag_r", 32'(bus.Tag), idx + 1);
                end else begin
                    idx = lowest_free(32'(snap_i), NI);
                    check("sb_er_i_wr", 32'(wr_i), 32'(1) << idx);
                    check("sb_er_r_quiet", 32'(wr_r), 0);
                    check("sb_tag_i", 32'(bus.Tag), NR + idx + 1);
                end
            end
        end
        for (int k = 0; k < NR; k++)
            if (!wr_r[k] && (!rand_en || $urandom_range(0, 3) == 0)) busy_r[k] = 1'b0;
        for (int k = 0; k < NI; k++)
            if (!wr_i[k] && (!rand_en || $urandom_range(0, 3) == 0)) busy_i[k] = 1'b0;
        busy_r = busy_r | wr_r;
        busy_i = busy_i | wr_i;
    end

    initial begin
`ifdef DESPACHO_CONTADORES_EN
        logic [7:0] base;
`endif
        bus.Flush = 1'b0;
        rst_n     = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Basic ADD
        push(16'h4000);
        wait_pop();
        check("basic_ocupado_busca", 32'(bus.Ocupado), 1);
        step();
        check("basic_pop_one_cycle", 32'(bus.Pop), 0);
        step();
        check("basic_er_r_wr", 32'(bus.ER_R_Wr), 32'b001);
        check("basic_tag", 32'(bus.Tag), 1);
        check("basic_instr_out", 32'(bus.Instr_Out), 32'h4000);
        step();
        check("basic_wr_clear", 32'({bus.ER_R_Wr, bus.ER_I_Wr}), 0);
        check("basic_tag_clear", 32'(bus.Tag), 0);

        // Station selection
        force_i = 2'b01;
        push(16'h8000);
        wait_pop();
        step();
        step();
        check("sel_er_i_wr", 32'(bus.ER_I_Wr), 32'b10);
        check("sel_tag", 32'(bus.Tag), 5);
        force_i = '0;
        drain();

        // Stall and release, with a second instruction waiting in the queue
`ifdef DESPACHO_CONTADORES_EN
        base = stalls;
`endif
        force_r = 3'b111;
        push(16'h6000);
        wait_pop();
        push(16'h4001);
        step();
        repeat (4) begin
            step();
            check("stall_no_wr", 32'({bus.ER_R_Wr, bus.ER_I_Wr}), 0);
            check("stall_no_pop", 32'(bus.Pop), 0);
            check("stall_ocupado", 32'(bus.Ocupado), 1);
        end
        force_r = 3'b011;
        step();
        check("stall_release_wr", 32'(bus.ER_R_Wr), 32'b100);
        check("stall_release_tag", 32'(bus.Tag), 3);
`ifdef DESPACHO_CONTADORES_EN
        check("stall_count", 32'(8'(stalls - base)), 4);
`endif
        force_r = '0;
        drain();

        // Invalid opcode
`ifdef DESPACHO_CONTADORES_EN
        base = descartadas;
`endif
        push(16'h0005);
        wait_pop();
        step();
        step();
        check("inv_no_wr", 32'({bus.ER_R_Wr, bus.ER_I_Wr}), 0);
        check("inv_ocupado", 32'(bus.Ocupado), 0);
`ifdef DESPACHO_CONTADORES_EN
        check("inv_descartadas", 32'(8'(descartadas - base)), 1);
`endif
        drain();

        // Flush during BUSCA
        push(16'h4000);
        wait_pop();
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        sb.delete();
        check("flush_ocupado", 32'(bus.Ocupado), 0);
        check("flush_tag", 32'(bus.Tag), 0);
        repeat (3) begin
            step();
            check("flush_no_wr", 32'({bus.ER_R_Wr, bus.ER_I_Wr}), 0);
            check("flush_no_pop", 32'(bus.Pop), 0);
        end
        push(16'h6002);
        wait_pop();
        step();
        step();
        check("post_flush_wr", 32'(bus.ER_R_Wr), 32'b001);
        drain();

        // Reset while stalled in EMITE
        force_r = 3'b111;
        push(16'h4000);
        wait_pop();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        force_r   = '0;
        n_writes  = 0;
        n_invalid = 0;
        step();
        step();
        rst_n = 1'b1;
        repeat (4) begin
            step();
            check("midreset_no_pop", 32'(bus.Pop), 0);
            check("midreset_idle", 32'({bus.Ocupado, bus.ER_R_Wr, bus.ER_I_Wr}), 0);
        end

        // Empty held high
        pause = 1'b1;
        push(16'h8003);
        repeat (10) begin
            step();
            check("empty_no_pop", 32'(bus.Pop), 0);
            check("empty_ocupado", 32'(bus.Ocupado), 0);
        end
        pause = 1'b0;
        wait_pop();
        drain();

        // Randomized traffic
        rand_en = 1'b1;
        for (int n = 0; n < 80; n++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 5));
            push({op, 13'($urandom)});
            repeat ($urandom_range(0, 6)) step();
            pause = ($urandom_range(0, 5) == 0);
        end
        pause = 1'b0;
        drain();
`ifdef DESPACHO_CONTADORES_EN
        check("final_emitidas", 32'(emitidas), 32'(8'(n_writes)));
        check("final_descartadas", 32'(descartadas), 32'(8'(n_invalid)));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/unidade_despacho.md
# unidade_despacho

Consumer side of the instruction queue: pulls instructions from the queue with `Pop`, latches each one, decodes the opcode and writes it into a free reservation station. ADD/SUB go to the R-type stations, LD/ST to the I-type stations. The block sits between the instruction queue and the Tomasulo reservation stations, and is the only agent that drives the queue's `Pop`.

## Interface
- `NUM_ER_R`, 3: number of R-type reservation stations (ADD/SUB).
- `NUM_ER_I`, 2: number of I-type reservation stations (LD/ST).
- Constraint: `NUM_ER_R + NUM_ER_I` ≤ 7.
- `Clock`  in  1  single clock; all state on posedge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Instrucao`  in  16  instruction from the queue; opcode = [15:13].
- `Empty`  in  1  queue empty flag.
- `Flush`  in  1  synchronous abort of any in-flight instruction.
- `ER_R_Busy`  in  `NUM_ER_R`  per-station busy, R-type.
- `ER_I_Busy`  in  `NUM_ER_I`  per-station busy, I-type.
- `Pop`  out  1  registered one-cycle request to the queue.
- `ER_R_Wr`  out  `NUM_ER_R`  one-hot write strobe, R-type stations.
- `ER_I_Wr`  out  `NUM_ER_I`  one-hot write strobe, I-type stations.
- `Instr_Out`  out  16  latched instruction, valid while any `*_Wr` bit is high.
- `Tag`  out  3  station tag of the write; 0 = none.
- `Ocupado`  out  1  high in every state other than OCIOSO.

## Operation
- Opcodes: ADD = 3'd2, SUB = 3'd3, LD = 3'd4, ST = 3'd5. Every other opcode, including the queue's empty-slot pattern 16'h0005, is invalid.
- FSM states:
  - **OCIOSO**: if `!Empty`, drive `Pop` = 1 for one cycle and go to BUSCA. Otherwise stay.
  - **BUSCA**: `Pop` = 0. At the next posedge, capture `Instrucao` into `Instr_Out` and go to EMITE.
  - **EMITE**:
    - Valid R opcode: select the lowest-index station with `ER_R_Busy[i]` = 0. Pulse `ER_R_Wr[i]` for one cycle with `Tag` = i+1, then go to OCIOSO.
    - Valid I opcode: select the lowest-index station with `ER_I_Busy[j]` = 0. Pulse `ER_I_Wr[j]` for one cycle with `Tag` = `NUM_ER_R`+j+1, then go to OCIOSO.
    - No free station of the required class: stay in EMITE (stall). Strobes stay 0, `Instr_Out` is held, `Pop` is not asserted.
    - Invalid opcode: no strobe, go to OCIOSO (the instruction is discarded).
- At most one `*_Wr` bit is high in any cycle. Strobes and `Tag` are registered, and `Tag` returns to 0 the cycle after a write.
- A station must raise its Busy bit no later than the cycle after its Wr strobe. The FSM cannot return to EMITE sooner than that.
- `Flush`, in any state: at the next posedge go to OCIOSO and clear `Pop`, the strobes and `Tag`. `Flush` overrides a write that would occur in the same cycle. An instruction already popped is dropped.

## Timing
- Reset (`Reset_n` low, asynchronous): state = OCIOSO, `Pop` = 0, `ER_R_Wr` = 0, `ER_I_Wr` = 0, `Instr_Out` = 16'h0005, `Tag` = 0, `Ocupado` = 0. Reset asserted mid-operation drops the in-flight instruction immediately.
- Handshake with the queue:
  - `Pop` rises at posedge t0.
  - The queue samples it at the negedge of cycle t0 and updates `Instrucao` before posedge t1.
  - The block captures `Instrucao` at posedge t1.
- Write latency with no stall: strobe is high in cycle t2, so the peak rate is 1 instruction per 3 cycles.
- `Empty` is sampled only in OCIOSO. `Pop` is never high for two consecutive cycles.
- Simultaneous free stations: the lowest index wins.
- Busy changing while stalled in EMITE: the write is issued on the first posedge at which a station of the required class is seen free.

## Configuration
- `DESPACHO_CONTADORES_EN`, when defined, adds three 8-bit output ports, all reset to 0:
  - `Emitidas`: increments on each write.
  - `Descartadas`: increments on each invalid opcode.
  - `Stalls`: increments on each cycle spent stalled in EMITE.
- All three counters wrap from 255 to 0. `Flush` does not clear them.
- When the macro is not defined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- **Basic ADD write**: reset, `Empty` = 0, `Instrucao` = 16'h4000 (ADD), all Busy = 0 → `Pop` high in cycle 1 only, `ER_R_Wr` = 3'b001 in cycle 3, `Tag` = 1, `Instr_Out` = 16'h4000.
- **Station selection**: LD 16'h8000 with `ER_I_Busy` = 2'b01 → `ER_I_Wr` = 2'b10, `Tag` = 5.
- **Stall and release**: SUB with `ER_R_Busy` = 3'b111 for 4 cycles, then 3'b011 → no strobe and no `Pop` while busy, then `ER_R_Wr` = 3'b100, `Tag` = 3; `Stalls` = 4 with the macro defined.
- **Invalid opcode**: `Instrucao` = 16'h0005 → no strobe, return to OCIOSO, `Descartadas` = 1 with the macro defined.
- **Flush and reset mid-operation**: `Flush` in BUSCA, then a separate run with `Reset_n` low in EMITE → no strobe, all outputs at reset values, next `Pop` only after `Empty` is seen 0 in OCIOSO.
- **Empty queue**: `Empty` = 1 held for 10 cycles → `Pop` stays 0, `Ocupado` stays 0.
